gray_conv_arbiter: RTL and testbench
====================================

# gray_conv_arbiter

Shares a single registered binary-to-Gray conversion stage among `N_REQ` requesters. Requesters present binary words with a level `req`; a round-robin arbiter grants one per transfer. The winner's word is converted (`G[W-1]=B[W-1]`, `G[i]=B[i+1]^B[i]`) and held in an output register with a valid/ready handshake toward the downstream consumer. It sits between the counter/pointer generators and any logic that needs Gray-coded values.

## Interface
- `N_REQ`, default 4: number of requesters, from 2 to 16.
- `WIDTH`, default 4: binary/Gray word width, 1 or more.
- `ID_W`, default 2: requester-ID width; must equal `$clog2(N_REQ)`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester request level.
- `bin_in` input N_REQ*WIDTH: requester k's word is at `[k*WIDTH +: WIDTH]`.
- `gnt` output N_REQ: one-hot, combinational; high in the cycle requester k's word is captured.
- `out_valid` output 1: output register holds an unconsumed result.
- `out_ready` input 1: downstream accepts the result.
- `gray_out` output WIDTH: Gray code of the granted word.
- `out_id` output ID_W: index of the requester that produced `gray_out`.

## Operation
- FSM states:
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
- Capture condition: `take = |req && (state==EMPTY || out_ready)`.
- When `take`:
  - `gnt` = one-hot winner.
  - At the clock edge: `gray_out <= gray(bin_in[winner])`, `out_id <= winner`, `last <= winner`, state to FULL.
- In FULL with `out_ready=1` and no `req`: go to EMPTY at the edge. `gray_out`/`out_id` keep their last values.
- In FULL with `out_ready=0`:
  - `gnt=0`.
  - `gray_out`, `out_id` and `out_valid` stay stable. Data must not change while valid and not ready.
- Round-robin rule: search starts at `last+1` (mod `N_REQ`) and picks the first set `req` bit. `last` changes only on `take`.
- Requester protocol:
  - Hold `req` and `bin_in` stable until `gnt` is seen.
  - Deassert `req` after `gnt` when no further word is pending.
  - A requester that keeps `req` high is re-arbitrated each transfer.
- Dropping `req` before `gnt` is legal. That request is simply not served.
- `out_ready` while EMPTY is ignored.
- Reset values (asynchronous, on `rst_n=0`): state EMPTY, `out_valid=0`, `gray_out=0`, `out_id=0`, `last=N_REQ-1` (so requester 0 wins first). `gnt` is 0 while in reset.
- Reset mid-transfer discards the held result. A requester whose `gnt` coincided with reset assertion must treat its word as lost.

## Timing
- Latency: result appears on `gray_out`/`out_valid` in the cycle after `gnt`.
- Throughput: one transfer per cycle when `out_ready=1` and `req` is nonzero. Simultaneous drain and capture in FULL produces no bubble.
- `gnt` depends combinationally on `req`, `out_ready`, state and `last`. There is no combinational path from `bin_in` to any output.
- Fairness: with all requesters asserting continuously, each is granted exactly once every `N_REQ` transfers.

## Configuration
- `GRAY_ARB_RR_EN` defined: round-robin arbitration as described above.
- `GRAY_ARB_RR_EN` undefined:
  - Fixed priority; the lowest set index always wins.
  - The `last` register is removed.
  - All other behaviour and timing are identical.

## Test plan
- Reset then single request: with `req=0001` and `bin_in[3:0]=4'b1011`, `gnt=0001` in cycle 0. Next cycle, `out_valid=1`, `gray_out=4'b1110`, `out_id=0`.
- Exhaustive conversion: requester 2 sends binary 0..15 with `out_ready=1`. Required output: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, back-to-back with no bubbles.
- Round-robin fairness (RR_EN): `req=1111` held for 8 transfers with `out_ready=1`. Required `out_id` sequence: 0,1,2,3,0,1,2,3.
- Fixed priority (RR_EN undefined): the same stimulus yields `out_id=0` on every transfer. After requester 0 drops `req`, the sequence is 1,1,…
- Backpressure: `out_ready=0` for 5 cycles while FULL with `req=0110`. Required: `gnt=0`, and `gray_out`/`out_id` stable throughout. When `out_ready` rises, `gnt` fires in that same cycle and the new result appears next cycle.
- Async reset mid-stream: assert `rst_n=0` between clock edges while FULL. `out_valid`, `gray_out` and `out_id` go to 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin/fixed-priority arbiter sharing one registered binary-to-Gray stage.
// Define GRAY_ARB_RR_EN for round-robin; when undefined the lowest set index always wins.
module gray_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   bin_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         gray_out,
    output logic [ID_W-1:0]          out_id
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic              take;
    logic [ID_W-1:0]   winner;
    logic [WIDTH-1:0]  win_bin;
    logic [WIDTH-1:0]  gray_d;
    logic [WIDTH-1:0]  gray_q;
    logic [ID_W-1:0]   id_q;

    function automatic logic [ID_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
        lowest_set = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (v[k]) lowest_set = ID_W'(k);
        end
    endfunction

`ifdef GRAY_ARB_RR_EN
    logic [ID_W-1:0]  last_q;
    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] hi_req;

    // Requests above last win first; otherwise wrap around to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < N_REQ; k++) begin
            hi_mask[k] = (ID_W'(k) > last_q);
        end
        hi_req = req & hi_mask;
        winner = (|hi_req) ? lowest_set(hi_req) : lowest_set(req);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ID_W'(N_REQ - 1);
        end else if (take) begin
            last_q <= winner;
        end
    end
`else
    always_comb begin
        winner = lowest_set(req);
    end
`endif

    // Gating with rst_n keeps gnt low while reset is held.
    always_comb begin
        take = rst_n && (|req) && ((state_q == StEmpty) || out_ready);
        gnt  = take ? (N_REQ'(1) << winner) : '0;
    end

    always_comb begin
        win_bin = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == ID_W'(k)) win_bin = bin_in[k*WIDTH +: WIDTH];
        end
        gray_d = win_bin ^ (win_bin >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (take) state_d = StFull;
            StFull: begin
                if (take)           state_d = StFull;
                else if (out_ready) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StFull);
        gray_out  = gray_q;
        out_id    = id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= '0;
            id_q   <= '0;
        end else if (take) begin
            gray_q <= gray_d;
            id_q   <= winner;
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter against a behavioural transfer model.
module tb_gray_conv_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int ID_W = 2;
    localparam int BW   = N * W;
    localparam int VW   = N + 1 + W + ID_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [BW-1:0] bin_in;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  gray_out;
    logic [ID_W-1:0] out_id;

    int n_cmp = 0;
    int n_err = 0;

    bit           m_valid;
    logic [W-1:0] m_gray;
    int           m_id;
    int           m_last;

    gray_conv_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gray_out  (gray_out),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    function automatic int model_winner(input logic [N-1:0] r, input int last);
`ifdef GRAY_ARB_RR_EN
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    function automatic logic [W-1:0] model_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    function automatic bit model_take();
        return (rst_n === 1'b1) && (req != '0) && (!m_valid || out_ready);
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (model_take()) g[model_winner(req, m_last)] = 1'b1;
        return g;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {model_gnt(), m_valid, m_gray, ID_W'(m_id)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {gnt, out_valid, gray_out, out_id};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_gray  = '0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    task automatic advance();
        int w;
        if (model_take()) begin
            w       = model_winner(req, m_last);
            m_gray  = model_gray(bin_in[w*W +: W]);
            m_id    = w;
            m_last  = w;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input int k, input logic [W-1:0] v);
        bin_in = BW'($urandom);
        bin_in[k*W +: W] = v;
    endtask

    task automatic pulse_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = '1;
        #3;
        n_cmp++;
        if ({gnt, out_valid, gray_out, out_id} !== '0) begin
            n_err++;
            $display("FAIL reset_vals: got %h want 0", {gnt, out_valid, gray_out, out_id});
        end
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0) begin
            n_err++;
            $display("FAIL reset_gnt: got %b want 0", gnt);
        end
        req = '0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req = 4'b0001;
        out_ready = 1'b0;
        set_bin(0, 4'b1011);
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL single_gnt: got %h want %h (gnt 0001)", obs_vec(), exp_vec());
        end
        advance();
        req = '0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, gray_out, out_id} !== {1'b1, 4'b1110, 2'd0} || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL single_result: got v%b g%b id%0d want v1 g1110 id0",
                     out_valid, gray_out, out_id);
        end
        out_ready = 1'b1;
        advance();
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                   4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        out_ready = 1'b1;
        for (int v = 0; v <= 16; v++) begin
            req = (v < 16) ? 4'b0100 : 4'b0000;
            if (v < 16) set_bin(2, W'(v));
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL exhaustive_vec[%0d]: got %h want %h", v, obs_vec(), exp_vec());
            end
            if (v > 0) begin
                n_cmp++;
                if (gray_out !== tab[v-1] || out_valid !== 1'b1 || out_id !== 2'd2) begin
                    n_err++;
                    $display("FAIL exhaustive_gray[%0d]: got g%0d v%b id%0d want g%0d v1 id2",
                             v - 1, gray_out, out_valid, out_id, tab[v-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_fairness();
`ifdef GRAY_ARB_RR_EN
        int ids [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1};
`else
        int ids [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
        pulse_reset();
        out_ready = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            req = (t < 8) ? 4'b1111 : ((t < 12) ? 4'b1110 : 4'b0000);
            bin_in = BW'($urandom);
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL fairness_vec[%0d]: got %h want %h", t, obs_vec(), exp_vec());
            end
            if (t > 0) begin
                n_cmp++;
                if (out_id !== ID_W'(ids[t-1]) || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL fairness_id[%0d]: got id%0d v%b want id%0d v1",
                             t - 1, out_id, out_valid, ids[t-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] snap_gray;
        int           snap_id;
        req = 4'b0110;
        out_ready = 1'b1;
        bin_in = BW'($urandom);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL bp_capture: got %h want %h", obs_vec(), exp_vec());
        end
        advance();
        snap_gray = m_gray;
        snap_id   = m_id;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt !== '0 || out_valid !== 1'b1 || gray_out !== snap_gray ||
                out_id !== ID_W'(snap_id) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got gnt%b v%b g%0d id%0d want gnt0 v1 g%0d id%0d",
                         c, gnt, out_valid, gray_out, out_id, snap_gray, snap_id);
            end
            advance();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gnt === '0 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL bp_release: got %h want %h", obs_vec(), exp_vec());
        end
        advance();
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL bp_result: got %h want %h", obs_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        out_ready = 1'b0;
        set_bin(3, 4'b0101);
        @(negedge clk);
        advance();
        req = '0;
        #2;
        n_cmp++;
        if ({out_valid, gray_out, out_id} !== {1'b1, 4'b0111, 2'd3}) begin
            n_err++;
            $display("FAIL arst_pre: got v%b g%b id%0d want v1 g0111 id3",
                     out_valid, gray_out, out_id);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt, out_valid, gray_out, out_id} !== '0) begin
            n_err++;
            $display("FAIL arst_clear: got %h want 0", {gnt, out_valid, gray_out, out_id});
        end
        req = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec() || gnt !== '0) begin
            n_err++;
            $display("FAIL arst_hold: got %h want %h", obs_vec(), exp_vec());
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL arst_first: got gnt %b want 0001", gnt);
        end
        advance();
        req = '0;
        out_ready = 1'b1;
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom_range(0, 15));
            bin_in = BW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        bin_in = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_exhaustive();
        test_fairness();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
